lfsr_search_ctrl: RTL and testbench

Parametrised control path for the LFSR-addressed associative memory. It sequences writes, which store at the current write-LFSR address, and reads, which restart the read LFSR and step it while the datapath compares entries. Unlike the previous controller, it bounds every search by the number of valid entries. It tracks fill level, reports hit/miss with a done handshake, and handles clear and full conditions. It sits between the user strobe interface and the LFSR/memory/comparator datapath.

---
 rtl/lfsr_search_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_lfsr_search_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_search_ctrl.sv
// lfsr_search_ctrl: control path for the LFSR-addressed associative memory.
// Sequences writes, clears and bounded searches, tracks the fill level and
// reports hit/miss with a Done pulse. The search length is capped by the
// number of valid entries.
// Optional feature macro: LFSR_WRAP_EN -- when defined, a write while Full
// overwrites the oldest entry instead of being rejected.
module lfsr_search_ctrl #(
    parameter int LFSR_WIDTH = 8,
    parameter int DEPTH      = 255,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          WR_Ext,
    input  logic          RD_Ext,
    input  logic          Clear_Ext,
    input  logic          Compare_Found,
    output logic          RD,
    output logic          WR,
    output logic          Temp_Trigger,
    output logic          LFSR_Enable,
    output logic          LFSR_Reset,
    output logic          Data_Compare_Enable,
    output logic          Write_Advance,
    output logic          Busy,
    output logic          Done,
    output logic          Hit,
    output logic          Miss,
    output logic          Write_Reject,
    output logic          Full,
    output logic [CW-1:0] Fill_Count,
    output logic [CW-1:0] Search_Count
);

    // An LFSR of this width can only address 2^LFSR_WIDTH-1 entries, so an
    // oversized DEPTH is clamped to what the address sequence can reach.
    localparam int MAX_ENTRIES = (1 << LFSR_WIDTH) - 1;
    localparam int DEPTH_EFF   = (DEPTH > MAX_ENTRIES) ? MAX_ENTRIES : DEPTH;

    typedef enum logic [2:0] {
        S_START,
        S_WRITE,
        S_CLEAR,
        S_TEMP,
        S_SEARCH,
        S_RESULT
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_fill;
    logic [CW-1:0] r_search;
    logic          r_hit;
    logic          r_miss;
    logic          r_reject;

    logic [5:0]    w_ctrl;        // {RD, WR, Temp_Trigger, LFSR_Enable, LFSR_Reset, Data_Compare_Enable}
    logic          w_full;
    logic          w_accept;      // a request is taken in START this cycle
    logic          w_read_empty;  // read issued with no valid entries
    logic          w_reject;      // write refused because the memory is full
    logic          w_last;        // current compare is against the last valid entry

    assign w_full = (r_fill == CW'(DEPTH_EFF));
    assign w_last = (r_search == r_fill - 1'b1);

    // State register; reset aborts any operation back to START.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (Reset) r_state <= S_START;
        else       r_state <= w_state_next;
    end

    // Next-state selection and Moore control decode from the state register.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_next = r_state;
        w_ctrl       = 6'b000000;
        w_accept     = 1'b0;
        w_read_empty = 1'b0;
        w_reject     = 1'b0;
        unique case (r_state)
            S_START: begin
                w_accept = Clear_Ext | WR_Ext | RD_Ext;
                if (Clear_Ext) begin
                    w_state_next = S_CLEAR;
                end else if (WR_Ext) begin
                    if (!w_full) begin
                        w_state_next = S_WRITE;
                    end else begin
`ifdef LFSR_WRAP_EN
                        w_state_next = S_WRITE;
`else
                        w_state_next = S_RESULT;
                        w_reject     = 1'b1;
`endif
                    end
                end else if (RD_Ext) begin
                    if (r_fill == '0) begin
                        w_state_next = S_RESULT;
                        w_read_empty = 1'b1;
                    end else begin
                        w_state_next = S_TEMP;
                    end
                end
            end
            S_WRITE: begin
                w_ctrl       = 6'b010000;
                w_state_next = S_RESULT;
            end
            S_CLEAR: begin
                w_ctrl       = 6'b000010;
                w_state_next = S_RESULT;
            end
            S_TEMP: begin
                w_ctrl       = 6'b001010;
                w_state_next = S_SEARCH;
            end
            S_SEARCH: begin
                w_ctrl = 6'b100101;
                if (Compare_Found || w_last) w_state_next = S_RESULT;
            end
            S_RESULT: begin
                w_state_next = S_START;
            end
            default: begin
                w_state_next = S_START;
            end
        endcase
    end

    // Fill level, search length, result flags and the reject pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_fill   <= '0;
            r_search <= '0;
            r_hit    <= 1'b0;
            r_miss   <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_reject <= w_reject;
            unique case (r_state)
                S_START: begin
                    if (w_accept) begin
                        r_hit  <= 1'b0;
                        r_miss <= w_read_empty;
                    end
                    if (w_read_empty) r_search <= '0;
                end
                S_WRITE: begin
                    // A wrap-around write while full keeps the level at DEPTH.
                    if (!w_full) r_fill <= r_fill + 1'b1;
                end
                S_CLEAR: begin
                    r_fill <= '0;
                end
                S_TEMP: begin
                    r_search <= '0;
                end
                S_SEARCH: begin
                    r_search <= r_search + 1'b1;
                    // A match on the final entry is still a hit.
                    if (Compare_Found) r_hit  <= 1'b1;
                    else if (w_last)   r_miss <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign {RD, WR, Temp_Trigger, LFSR_Enable, LFSR_Reset, Data_Compare_Enable} = w_ctrl;
    assign Write_Advance = w_ctrl[4];
    assign Busy          = (r_state != S_START);
    assign Done          = (r_state == S_RESULT);
    assign Hit           = r_hit;
    assign Miss          = r_miss;
    assign Write_Reject  = r_reject;
    assign Full          = w_full;
    assign Fill_Count    = r_fill;
    assign Search_Count  = r_search;

endmodule

// File: tb/tb_lfsr_search_ctrl.sv
// Directed bench for lfsr_search_ctrl with a small reference model: each
// operation pushes its predicted result to a queue, which is popped and
// compared when Done is observed.
module tb_lfsr_search_ctrl;

    localparam int LW    = 3;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          Clock = 1'b0;
    logic          Reset;
    logic          WR_Ext;
    logic          RD_Ext;
    logic          Clear_Ext;
    logic          Compare_Found;
    logic          RD;
    logic          WR;
    logic          Temp_Trigger;
    logic          LFSR_Enable;
    logic          LFSR_Reset;
    logic          Data_Compare_Enable;
    logic          Write_Advance;
    logic          Busy;
    logic          Done;
    logic          Hit;
    logic          Miss;
    logic          Write_Reject;
    logic          Full;
    logic [CW-1:0] Fill_Count;
    logic [CW-1:0] Search_Count;
    logic [5:0]    ctrl;

    assign ctrl = {RD, WR, Temp_Trigger, LFSR_Enable, LFSR_Reset, Data_Compare_Enable};

    lfsr_search_ctrl #(.LFSR_WIDTH(LW), .DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .WR_Ext(WR_Ext), .RD_Ext(RD_Ext),
        .Clear_Ext(Clear_Ext), .Compare_Found(Compare_Found), .RD(RD), .WR(WR),
        .Temp_Trigger(Temp_Trigger), .LFSR_Enable(LFSR_Enable), .LFSR_Reset(LFSR_Reset),
        .Data_Compare_Enable(Data_Compare_Enable), .Write_Advance(Write_Advance),
        .Busy(Busy), .Done(Done), .Hit(Hit), .Miss(Miss), .Write_Reject(Write_Reject),
        .Full(Full), .Fill_Count(Fill_Count), .Search_Count(Search_Count)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string tag;
        int    fill;
        bit    hit;
        bit    miss;
        int    srch;
        int    lat;     // edges from the sampling edge until Done is visible
        bit    rej;
        int    n_wr;    // cycles with WR high
        int    n_step;  // cycles with LFSR_Enable high
        int    n_lrst;  // cycles with LFSR_Reset high
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;
    int   m_fill  = 0;
    int   m_srch  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Reference model: predicts the outcome of one request issued in START.
    task automatic predict(input bit wr, input bit rd, input bit clr, input int hit_at,
                           input string tag);
        exp_t e;
        e.tag = tag; e.hit = 0; e.miss = 0; e.rej = 0;
        e.n_wr = 0; e.n_step = 0; e.n_lrst = 0; e.lat = 2;
        if (clr) begin
            m_fill   = 0;
            e.n_lrst = 1;
        end else if (wr) begin
            if (m_fill < DEPTH) begin
                m_fill++;
                e.n_wr = 1;
            end else begin
`ifdef LFSR_WRAP_EN
                e.n_wr = 1;
`else
                e.lat = 1;
                e.rej = 1;
`endif
            end
        end else if (rd) begin
            if (m_fill == 0) begin
                e.miss = 1; m_srch = 0; e.lat = 1;
            end else begin
                e.n_lrst = 1;
                if (hit_at >= 1 && hit_at <= m_fill) begin
                    e.hit = 1; m_srch = hit_at;
                end else begin
                    e.miss = 1; m_srch = m_fill;
                end
                e.n_step = m_srch;
                e.lat    = m_srch + 2;
            end
        end
        e.fill = m_fill;
        e.srch = m_srch;
        sb.push_back(e);
    endtask

    // Runs the DUT from the cycle after the sampling edge until Done, driving
    // Compare_Found on SEARCH cycle hit_at, then checks the popped prediction.
    task automatic finish_op(input int hit_at);
        int   n = 1;
        int   idx = 0;
        int   c_wr = 0;
        int   c_step = 0;
        int   c_lrst = 0;
        exp_t e;
        while (!Done && n < 64) begin
            if (WR) begin
                c_wr++;
                check("write_vector", {26'd0, ctrl}, {26'd0, 6'b010000});
                check("write_advance", {31'd0, Write_Advance}, 32'd1);
            end
            if (Temp_Trigger) check("temp_vector", {26'd0, ctrl}, {26'd0, 6'b001010});
            if (LFSR_Reset && !Temp_Trigger) check("clear_vector", {26'd0, ctrl}, {26'd0, 6'b000010});
            if (LFSR_Enable) c_step++;
            if (LFSR_Reset) c_lrst++;
            if (RD) begin
                idx++;
                if (idx == 1) check("search_vector", {26'd0, ctrl}, {26'd0, 6'b100101});
                Compare_Found = (idx == hit_at);
            end else begin
                Compare_Found = 1'b0;
            end
            tick();
            n++;
        end
        Compare_Found = 1'b0;
        check("done_seen", {31'd0, Done}, 32'd1);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_latency"}, n, e.lat);
            check({e.tag, "_fill"}, {{(32-CW){1'b0}}, Fill_Count}, e.fill);
            check({e.tag, "_hit"}, {31'd0, Hit}, {31'd0, e.hit});
            check({e.tag, "_miss"}, {31'd0, Miss}, {31'd0, e.miss});
            check({e.tag, "_search_count"}, {{(32-CW){1'b0}}, Search_Count}, e.srch);
            check({e.tag, "_reject"}, {31'd0, Write_Reject}, {31'd0, e.rej});
            check({e.tag, "_result_vector"}, {26'd0, ctrl}, 32'd0);
            check({e.tag, "_busy_result"}, {31'd0, Busy}, 32'd1);
            check({e.tag, "_wr_cycles"}, c_wr, e.n_wr);
            check({e.tag, "_step_cycles"}, c_step, e.n_step);
            check({e.tag, "_lfsr_reset_cycles"}, c_lrst, e.n_lrst);
            tick();
            check({e.tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
            check({e.tag, "_busy_idle"}, {31'd0, Busy}, 32'd0);
            check({e.tag, "_reject_pulse"}, {31'd0, Write_Reject}, 32'd0);
            check({e.tag, "_hit_held"}, {31'd0, Hit}, {31'd0, e.hit});
            check({e.tag, "_miss_held"}, {31'd0, Miss}, {31'd0, e.miss});
        end
    endtask

    task automatic run_op(input bit wr, input bit rd, input bit clr, input int hit_at,
                          input string tag);
        predict(wr, rd, clr, hit_at, tag);
        WR_Ext = wr; RD_Ext = rd; Clear_Ext = clr;
        tick();
        WR_Ext = 1'b0; RD_Ext = 1'b0; Clear_Ext = 1'b0;
        finish_op(hit_at);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outputs"},
              {19'd0, RD, WR, Temp_Trigger, LFSR_Enable, LFSR_Reset, Data_Compare_Enable,
               Write_Advance, Busy, Done, Hit, Miss, Write_Reject, Full}, 32'd0);
        check({tag, "_fill"}, {{(32-CW){1'b0}}, Fill_Count}, 32'd0);
        check({tag, "_search_count"}, {{(32-CW){1'b0}}, Search_Count}, 32'd0);
    endtask

    initial begin
        Reset = 1'b1; WR_Ext = 1'b0; RD_Ext = 1'b0; Clear_Ext = 1'b0; Compare_Found = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        Reset = 1'b0;
        tick();

        // Read with no valid entries: straight to RESULT with a miss.
        run_op(1'b0, 1'b1, 1'b0, 0, "read_empty");

        // Three writes, then a hit on the 2nd compare and a full-length miss.
        run_op(1'b1, 1'b0, 1'b0, 0, "write1");
        run_op(1'b1, 1'b0, 1'b0, 0, "write2");
        run_op(1'b1, 1'b0, 1'b0, 0, "write3");
        check("fill_after_3_writes", {{(32-CW){1'b0}}, Fill_Count}, 32'd3);
        run_op(1'b0, 1'b1, 1'b0, 2, "read_hit2");
        run_op(1'b0, 1'b1, 1'b0, 0, "read_miss3");

        // WR and RD together: write wins; RD held through the write is only
        // sampled once Busy has fallen.
        predict(1'b1, 1'b0, 1'b0, 0, "wr_rd_write");
        WR_Ext = 1'b1; RD_Ext = 1'b1;
        tick();
        WR_Ext = 1'b0;
        check("wr_rd_no_temp", {31'd0, Temp_Trigger}, 32'd0);
        finish_op(0);
        predict(1'b0, 1'b1, 1'b0, 0, "held_read");
        tick();
        RD_Ext = 1'b0;
        check("held_read_temp", {31'd0, Temp_Trigger}, 32'd1);
        finish_op(0);
        check("full_flag", {31'd0, Full}, 32'd1);

        // Write while full: rejected, or wraps when the feature is enabled.
        run_op(1'b1, 1'b0, 1'b0, 0, "write_full");
        check("fill_after_full_write", {{(32-CW){1'b0}}, Fill_Count}, DEPTH);

        // Match on the last valid entry counts as a hit.
        run_op(1'b0, 1'b1, 1'b0, DEPTH, "read_hit_last");

        // Clear has priority over simultaneous write and read.
        run_op(1'b1, 1'b1, 1'b1, 0, "clear_priority");
        run_op(1'b1, 1'b0, 1'b0, 0, "write_a");
        run_op(1'b1, 1'b0, 1'b0, 0, "write_b");
        run_op(1'b0, 1'b0, 1'b1, 0, "clear_after_2");
        run_op(1'b0, 1'b1, 1'b0, 0, "read_after_clear");

        // Reset on the 2nd SEARCH cycle aborts to START with everything zero.
        run_op(1'b1, 1'b0, 1'b0, 0, "write_c");
        run_op(1'b1, 1'b0, 1'b0, 0, "write_d");
        run_op(1'b1, 1'b0, 1'b0, 0, "write_e");
        RD_Ext = 1'b1;
        tick();
        RD_Ext = 1'b0;
        tick();
        tick();
        check("abort_in_search2", {31'd0, RD}, 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        m_fill = 0;
        m_srch = 0;
        check_all_zero("abort");
        run_op(1'b0, 1'b1, 1'b0, 0, "read_after_abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
